// File: rtl/parking_gate_ctrl_if.sv
// Sensor/keypad/actuator bundle of the parking entry gate controller.
// master drives the sensors and keypad, slave (the controller) drives the gate status.
interface parking_gate_ctrl_if #(
    parameter int unsigned PIN_W = 8,
    parameter int unsigned CNT_W = 5
);
    logic             sensorA;
    logic             sensorB;
    logic [PIN_W-1:0] pass;
    logic             passValid;
    logic             carExit;
    logic             gateState;
    logic             blockAlarm;
    logic             wrongPinAlarm;
    logic [CNT_W-1:0] occupancy;
    logic             full;

    modport master (
        output sensorA, sensorB, pass, passValid, carExit,
        input  gateState, blockAlarm, wrongPinAlarm, occupancy, full
    );

    modport slave (
        input  sensorA, sensorB, pass, passValid, carExit,
        output gateState, blockAlarm, wrongPinAlarm, occupancy, full
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Single entry gate: PIN check, tailgate detection, wrong-PIN lockout, lot occupancy.
// Optional PIN-entry timeout is built in when PGC_TIMEOUT_EN is defined.
module parking_gate_ctrl #(
    parameter int unsigned      PIN_W     = 8,
    parameter logic [PIN_W-1:0] PIN       = PIN_W'(44),
    parameter int unsigned      MAX_TRIES = 3,
    parameter int unsigned      CAPACITY  = 16,
    parameter int unsigned      CNT_W     = 5,
    parameter int unsigned      TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                reset,
    parking_gate_ctrl_if.slave  bus
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_BLOCKED = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;

    if (MAX_TRIES < 1 || CAPACITY < 1 || TIMEOUT < 1 || (64'd1 << CNT_W) <= 64'(CAPACITY))
    begin : g_bad_params
        $error("parking_gate_ctrl: invalid parameter combination");
    end

    logic [2:0]       state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             seen_b_q, seen_b_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             full_q, gate_q, block_q, wrong_q;
    logic             pin_ok;
    logic             entered;

`ifdef PGC_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timed_out;

    assign timed_out = (tmr_q == TMR_W'(TIMEOUT - 1));
`endif

    assign pin_ok = bus.passValid && (bus.pass == PIN);

    // Next-state, try counter and vehicle-pass tracking
    always_comb begin
        state_d  = state_q;
        tries_d  = tries_q;
        seen_b_d = 1'b0;
        entered  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.sensorA && !full_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.passValid) begin
                    if (bus.pass == PIN) begin
                        state_d = S_OPEN;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_q + 1'b1 == TRY_W'(MAX_TRIES)) state_d = S_LOCKED;
                    end
                end else if (!bus.sensorA) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                end
`ifdef PGC_TIMEOUT_EN
                else if (timed_out) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                end
`endif
            end
            S_OPEN: begin
                seen_b_d = seen_b_q | bus.sensorB;
                // Tailgate wins over a vehicle completing its pass
                if (bus.sensorA && bus.sensorB) begin
                    state_d = S_BLOCKED;
                end else if (seen_b_q && !bus.sensorB && !bus.sensorA) begin
                    state_d = S_IDLE;
                    entered = 1'b1;
                end
            end
            S_BLOCKED: begin
                if (pin_ok) state_d = S_IDLE;
            end
            S_LOCKED: begin
                if (pin_ok) begin
                    state_d = S_OPEN;
                    tries_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating occupancy; a simultaneous entry and exit cancel out
    always_comb begin
        occ_d = occ_q;
        if (entered && !bus.carExit) begin
            if (occ_q != CNT_W'(CAPACITY)) occ_d = occ_q + 1'b1;
        end else if (bus.carExit && !entered) begin
            if (occ_q != '0) occ_d = occ_q - 1'b1;
        end
    end

`ifdef PGC_TIMEOUT_EN
    always_comb begin
        tmr_d = '0;
        if (state_q == S_WAIT && state_d == S_WAIT && !bus.passValid) tmr_d = tmr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmr_q <= '0;
        else       tmr_q <= tmr_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tries_q  <= '0;
            seen_b_q <= 1'b0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            gate_q   <= 1'b0;
            block_q  <= 1'b0;
            wrong_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tries_q  <= tries_d;
            seen_b_q <= seen_b_d;
            occ_q    <= occ_d;
            full_q   <= (occ_d == CNT_W'(CAPACITY));
            gate_q   <= (state_d == S_OPEN);
            block_q  <= (state_d == S_BLOCKED);
            wrong_q  <= (state_d == S_LOCKED);
        end
    end

    assign bus.gateState     = gate_q;
    assign bus.blockAlarm    = block_q;
    assign bus.wrongPinAlarm = wrong_q;
    assign bus.occupancy     = occ_q;
    assign bus.full          = full_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed vector table, reset/timeout sequences,
// then random stimulus against a behavioural lot model. Small CAPACITY to reach "full".
module tb_parking_gate_ctrl;

    localparam int unsigned CAP   = 2;
    localparam int unsigned CW    = 2;
    localparam int unsigned TRIES = 3;
    localparam int unsigned TMO   = 64;
    localparam logic [7:0]  GOOD  = 8'd44;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    parking_gate_ctrl_if #(.PIN_W(8), .CNT_W(CW)) bus ();

    parking_gate_ctrl #(
        .PIN_W(8), .PIN(GOOD), .MAX_TRIES(TRIES), .CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit g, input bit b, input bit w,
                           input int occ, input bit f);
        chk({tag, ".gateState"},     int'(bus.gateState),     int'(g));
        chk({tag, ".blockAlarm"},    int'(bus.blockAlarm),    int'(b));
        chk({tag, ".wrongPinAlarm"}, int'(bus.wrongPinAlarm), int'(w));
        chk({tag, ".occupancy"},     int'(bus.occupancy),     occ);
        chk({tag, ".full"},          int'(bus.full),          int'(f));
    endtask

    task automatic apply(input bit sa, input bit sb, input logic [7:0] pw,
                         input bit pv, input bit ce);
        bus.sensorA   = sa;
        bus.sensorB   = sb;
        bus.pass      = pw;
        bus.passValid = pv;
        bus.carExit   = ce;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: what the lot and gate should look like after each cycle
    typedef enum int {M_IDLE, M_WAIT, M_OPEN, M_BLOCKED, M_LOCKED} mode_t;
    mode_t m_mode;
    int    m_tries, m_occ, m_wait;
    bit    m_seen;

    task automatic model_reset();
        m_mode = M_IDLE; m_tries = 0; m_occ = 0; m_wait = 0; m_seen = 0;
    endtask

    task automatic model_step(input bit sa, input bit sb, input logic [7:0] pw,
                              input bit pv, input bit ce);
        bit car_in = 0;
        bit ok = pv && (pw == GOOD);
        case (m_mode)
            M_IDLE:
                if (sa && m_occ != int'(CAP)) begin m_mode = M_WAIT; m_wait = 0; end
            M_WAIT: begin
                if (pv) begin
                    m_wait = 0;
                    if (ok) begin m_mode = M_OPEN; m_tries = 0; m_seen = 0; end
                    else begin
                        m_tries++;
                        if (m_tries == int'(TRIES)) m_mode = M_LOCKED;
                    end
                end else if (!sa) begin
                    m_mode = M_IDLE; m_tries = 0;
                end else begin
`ifdef PGC_TIMEOUT_EN
                    m_wait++;
                    if (m_wait == int'(TMO)) begin m_mode = M_IDLE; m_tries = 0; end
`endif
                end
            end
            M_OPEN: begin
                if (sa && sb) m_mode = M_BLOCKED;
                else if (sb) m_seen = 1;
                else if (m_seen && !sa) begin car_in = 1; m_mode = M_IDLE; end
            end
            M_BLOCKED: if (ok) m_mode = M_IDLE;
            M_LOCKED:  if (ok) begin m_mode = M_OPEN; m_tries = 0; m_seen = 0; end
            default:   m_mode = M_IDLE;
        endcase
        if (car_in && !ce)      m_occ = (m_occ < int'(CAP)) ? m_occ + 1 : m_occ;
        else if (ce && !car_in) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
    endtask

    typedef struct {
        bit sa, sb; logic [7:0] pw; bit pv, ce;
        bit g, b, w; int occ; bit f;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit sa, bit sb, logic [7:0] pw, bit pv, bit ce,
                                bit g, bit b, bit w, int occ, bit f);
        vec_t v;
        v.sa = sa; v.sb = sb; v.pw = pw; v.pv = pv; v.ce = ce;
        v.g = g; v.b = b; v.w = w; v.occ = occ; v.f = f;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // entry with correct PIN, vehicle passes through
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,8'd44,1,0, 1,0,0,0,0));
        vecs.push_back(mk(0,1, 8'd0,0,0, 1,0,0,0,0));
        vecs.push_back(mk(0,0, 8'd0,0,0, 0,0,0,1,0));
        // wrong-PIN lockout and release
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,1,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,0,1,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,0,1,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,1,1,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,1,1,0));
        vecs.push_back(mk(1,0,8'd44,1,0, 1,0,0,1,0));
        // tailgate while open
        vecs.push_back(mk(1,1, 8'd0,0,0, 0,1,0,1,0));
        vecs.push_back(mk(1,0, 8'd9,1,0, 0,1,0,1,0));
        vecs.push_back(mk(0,0,8'd44,1,0, 0,0,0,1,0));
        // fill the lot, entry refused while full, exit clears full
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,1,0));
        vecs.push_back(mk(1,0,8'd44,1,0, 1,0,0,1,0));
        vecs.push_back(mk(0,1, 8'd0,0,0, 1,0,0,1,0));
        vecs.push_back(mk(0,0, 8'd0,0,0, 0,0,0,2,1));
        vecs.push_back(mk(1,0,8'd44,1,0, 0,0,0,2,1));
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,2,1));
        vecs.push_back(mk(0,0, 8'd0,0,1, 0,0,0,1,0));
        // entry and exit on the same edge, exit saturating at zero
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,1,0));
        vecs.push_back(mk(1,0,8'd44,1,0, 1,0,0,1,0));
        vecs.push_back(mk(0,1, 8'd0,0,0, 1,0,0,1,0));
        vecs.push_back(mk(0,0, 8'd0,0,1, 0,0,0,1,0));
        vecs.push_back(mk(0,0, 8'd0,0,1, 0,0,0,0,0));
        vecs.push_back(mk(0,0, 8'd0,0,1, 0,0,0,0,0));
        // leaving before a PIN forgets earlier wrong tries
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0, 8'd0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 0,0,0,0,0));
        vecs.push_back(mk(0,0, 8'd0,0,0, 0,0,0,0,0));
        // PIN ignored while open, exit honoured in OPEN at zero
        vecs.push_back(mk(1,0, 8'd0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,8'd44,1,0, 1,0,0,0,0));
        vecs.push_back(mk(1,0, 8'd7,1,0, 1,0,0,0,0));
        vecs.push_back(mk(0,1, 8'd0,0,1, 1,0,0,0,0));
        vecs.push_back(mk(0,0, 8'd0,0,0, 0,0,0,1,0));

        bus.sensorA = 0; bus.sensorB = 0; bus.pass = '0; bus.passValid = 0; bus.carExit = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i])
        begin
            apply(vecs[i].sa, vecs[i].sb, vecs[i].pw, vecs[i].pv, vecs[i].ce);
            chk_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].w, vecs[i].occ, vecs[i].f);
        end

        // async reset in the middle of an open cycle clears everything at once
        apply(1,0, 8'd0,0,0);
        apply(1,0,8'd44,1,0);
        chk("pre_reset.gateState", int'(bus.gateState), 1);
        chk("pre_reset.occupancy", int'(bus.occupancy), 1);
        #3;
        reset = 1'b1;
        #1;
        chk_out("async_reset", 0, 0, 0, 0, 0);
        bus.sensorA = 0; bus.passValid = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifdef PGC_TIMEOUT_EN
        // two wrong tries, then the entry times out; a later wrong PIN must not lock
        apply(1,0, 8'd0,0,0);
        apply(1,0, 8'd7,1,0);
        apply(1,0, 8'd7,1,0);
        repeat (70) apply(1,0, 8'd0,0,0);
        apply(1,0, 8'd7,1,0);
        chk("timeout.wrongPinAlarm", int'(bus.wrongPinAlarm), 0);
        apply(0,0, 8'd0,0,0);
`endif

        // random traffic against the reference model
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int n = 0; n < 4000; n++) begin
            bit sa, sb, pv, ce;
            logic [7:0] pw;
            int sel;
            sa  = ($urandom_range(0, 99) < 50);
            sb  = ($urandom_range(0, 99) < 40);
            pv  = ($urandom_range(0, 99) < 30);
            ce  = ($urandom_range(0, 99) < 10);
            sel = int'($urandom_range(0, 3));
            pw  = (sel < 2) ? GOOD : (sel == 2) ? 8'd7 : 8'($urandom);
            model_step(sa, sb, pw, pv, ce);
            apply(sa, sb, pw, pv, ce);
            chk_out($sformatf("rnd%0d", n), m_mode == M_OPEN, m_mode == M_BLOCKED,
                    m_mode == M_LOCKED, m_occ, m_occ == int'(CAP));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
